// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_transmitter_if.sv
// Holding-register write handshake between a host and the UART transmitter.
interface uart_transmitter_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
) ();
  logic                 tx_load;
  logic [DATA_BITS-1:0] THR_in;
  logic                 tx_ready;

  modport master (output tx_load, output THR_in, input  tx_ready);
  modport slave  (input  tx_load, input  THR_in, output tx_ready);
endinterface

// File: rtl/rise_detect.sv
// One-cycle pulse on each rising edge of a level signal sampled in sys_clk.
module rise_detect (
  input  logic sys_clk,
  input  logic rst,
  input  logic sig_in,
  output logic pulse_out
);
  logic sig_old;

  // Loading the live value during reset too means no edge is seen right after it.
  always_ff @(posedge sys_clk) begin
    if (rst) sig_old <= sig_in;
    else     sig_old <= sig_in;
  end

  assign pulse_out = sig_in & ~sig_old;
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one-deep THR feeding a shift register, paced by bclkx8 ticks.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                bclkx8,
  uart_transmitter_if.slave   host,
  output logic                tx_status,
  output logic                tx_data
);
  localparam int CW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  uart_state_t          state, state_n;
  logic [CW-1:0]        count, count_n;
  logic [BCW-1:0]       bit_count, bit_count_n;
  logic [DATA_BITS-1:0] thr, thr_n, tsr, tsr_n;
  logic                 thr_full, thr_full_n;
  logic                 tx_data_n, tx_ready_q;
  logic                 tick, last, xfer;

  rise_detect u_rise (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .sig_in    (bclkx8),
    .pulse_out (tick)
  );

  assign last = (count == CW'(OVERSAMPLE - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      bit_count  <= '0;
      thr        <= '0;
      tsr        <= '0;
      thr_full   <= 1'b0;
      tx_data    <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      count      <= count_n;
      bit_count  <= bit_count_n;
      thr        <= thr_n;
      tsr        <= tsr_n;
      thr_full   <= thr_full_n;
      tx_data    <= tx_data_n;
      tx_ready_q <= ~thr_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    bit_count_n = bit_count;
    thr_n       = thr;
    tsr_n       = tsr;
    thr_full_n  = thr_full;
    tx_data_n   = 1'b1;
    xfer        = 1'b0;

    if (tick) begin
      unique case (state)
        IDLE: begin
          if (thr_full) begin
            xfer        = 1'b1;
            state_n     = START;
            count_n     = '0;
            bit_count_n = '0;
          end
        end
        START: begin
          if (last) begin
            state_n = DATA;
            count_n = '0;
          end else count_n = count + CW'(1);
        end
        DATA: begin
          if (last) begin
            tsr_n       = tsr >> 1;
            bit_count_n = bit_count + BCW'(1);
            count_n     = '0;
            if (bit_count == BCW'(DATA_BITS - 1)) state_n = STOP;
          end else count_n = count + CW'(1);
        end
        STOP: begin
          if (last) begin
            count_n = '0;
            // A waiting byte starts its start bit on this same tick: no idle gap.
            if (thr_full) begin
              xfer        = 1'b1;
              state_n     = START;
              bit_count_n = '0;
            end else state_n = IDLE;
          end else count_n = count + CW'(1);
        end
      endcase
    end

    // Transfer needs a full THR and a load needs an empty one, so they never collide.
    if (xfer) begin
      tsr_n      = thr;
      thr_full_n = 1'b0;
    end else if (host.tx_load && !thr_full) begin
      thr_n      = host.THR_in;
      thr_full_n = 1'b1;
    end

    unique case (state_n)
      IDLE, STOP: tx_data_n = 1'b1;
      START:      tx_data_n = 1'b0;
      DATA:       tx_data_n = tsr_n[0];
    endcase
  end

  assign host.tx_ready = tx_ready_q;
  assign tx_status     = (state != IDLE);
endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized bench for uart_transmitter against a tick-level line model.
module tb_uart_transmitter;
  logic sys_clk = 1'b0;
  logic rst, bclkx8;
  logic tx_status, tx_data;

  uart_transmitter_if #(.DATA_BITS(8)) host_if ();

  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(8)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .bclkx8    (bclkx8),
    .host      (host_if),
    .tx_status (tx_status),
    .tx_data   (tx_data)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the line as a queue of per-tick values, THR as a valid flag plus byte.
  logic       m_prev, m_valid, m_line, m_stat, m_tick;
  logic [7:0] m_thr;
  logic       m_q[$];
  logic       cap[$];
  int         stat_ticks;
  int         b_left;
  bit         b_freeze;

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
      repeat (8) m_q.push_back(v);
    end
  endtask

  task automatic bclk_adv();
    if (!b_freeze) begin
      if (b_left <= 1) begin
        bclkx8 = ~bclkx8;
        b_left = $urandom_range(1, 3);
      end else b_left--;
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] d, input logic r);
    bit xfer;
    xfer = 0;
    bclk_adv();
    host_if.tx_load = ld;
    host_if.THR_in  = d;
    rst             = r;
    @(posedge sys_clk);
    m_tick = 1'b0;
    if (r) begin
      m_prev  = bclkx8;
      m_q.delete();
      m_valid = 1'b0;
      m_thr   = '0;
      m_line  = 1'b1;
      m_stat  = 1'b0;
    end else begin
      m_tick = bclkx8 && !m_prev;
      m_prev = bclkx8;
      if (m_tick) begin
        xfer = m_valid && (m_q.size() == 0);
        if (xfer) push_frame(m_thr);
        if (m_q.size() > 0) begin
          m_line = m_q.pop_front();
          m_stat = 1'b1;
        end else begin
          m_line = 1'b1;
          m_stat = 1'b0;
        end
      end
      if (xfer) m_valid = 1'b0;
      else if (ld && !m_valid) begin
        m_valid = 1'b1;
        m_thr   = d;
      end
    end
    #1;
    chk("tx_data",   32'(tx_data),          32'(m_line));
    chk("tx_status", 32'(tx_status),        32'(m_stat));
    chk("tx_ready",  32'(host_if.tx_ready), 32'(!m_valid));
    if (m_tick && tx_status) begin
      stat_ticks++;
      cap.push_back(tx_data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_ticks(input int n);
    int t = 0, k = 0;
    while (t < n && k < 5000) begin
      step(1'b0, 8'h00, 1'b0);
      if (m_tick) t++;
      k++;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!host_if.tx_ready && k < 2000) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("wait_ready_timeout", 32'(host_if.tx_ready), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((m_valid || m_q.size() > 0 || tx_status) && k < 4000) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("wait_done_timeout", 32'(tx_status), 32'd0);
    idle(12);
  endtask

  // Mid-bit sample of data bit i from each captured 80-tick frame.
  function automatic logic [31:0] decode(input int f);
    logic [7:0] b;
    if (cap.size() < (f + 1) * 80) return 32'hDEAD;
    for (int i = 0; i < 8; i++) b[i] = cap[f*80 + 8 + 8*i + 4];
    return 32'(b);
  endfunction

  task automatic clr();
    cap.delete();
    stat_ticks = 0;
  endtask

  initial begin
    bclkx8 = 1'b0; b_left = 2; b_freeze = 0;
    host_if.tx_load = 1'b0; host_if.THR_in = '0; rst = 1'b1;
    m_prev = 1'b0; m_valid = 1'b0; m_line = 1'b1; m_stat = 1'b0; m_tick = 1'b0; m_thr = '0;
    stat_ticks = 0;

    // Reset with a load alongside it that must be ignored.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(30);
    chk("post_reset_status", 32'(tx_status), 32'd0);

    // Single byte
    clr();
    step(1'b1, 8'hA5, 1'b0);
    wait_done();
    chk("a5_status_ticks", 32'(stat_ticks), 32'd80);
    chk("a5_byte", decode(0), 32'hA5);

    // Back-to-back
    clr();
    step(1'b1, 8'h55, 1'b0);
    wait_ticks(30);
    step(1'b1, 8'h0F, 1'b0);
    wait_done();
    chk("b2b_status_ticks", 32'(stat_ticks), 32'd160);
    chk("b2b_byte0", decode(0), 32'h55);
    chk("b2b_byte1", decode(1), 32'h0F);

    // Overflow
    clr();
    step(1'b1, 8'h11, 1'b0);
    wait_ready();
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("ovf_ready_low", 32'(host_if.tx_ready), 32'd0);
    wait_done();
    chk("ovf_status_ticks", 32'(stat_ticks), 32'd160);
    chk("ovf_byte0", decode(0), 32'h11);
    chk("ovf_byte1", decode(1), 32'h22);

    // Reset in the middle of data bit 3
    step(1'b1, 8'($urandom), 1'b0);
    wait_ticks(1 + 8 + 3*8 + 3);
    chk("mid_status_busy", 32'(tx_status), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_rst_line", 32'(tx_data), 32'd1);
    chk("mid_rst_ready", 32'(host_if.tx_ready), 32'd1);
    idle(5);
    clr();
    step(1'b1, 8'h81, 1'b0);
    wait_done();
    chk("mid_status_ticks", 32'(stat_ticks), 32'd80);
    chk("mid_byte", decode(0), 32'h81);

    // Frozen bclkx8 mid-frame: outputs must hold
    clr();
    step(1'b1, 8'hC3, 1'b0);
    wait_ticks(20);
    b_freeze = 1;
    idle(40);
    b_freeze = 0;
    wait_done();
    chk("frz_status_ticks", 32'(stat_ticks), 32'd80);
    chk("frz_byte", decode(0), 32'hC3);

    // Random loads, random baud jitter
    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 7) == 0), 8'($urandom), 1'b0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART. It accepts bytes over a one-deep holding-register handshake and shifts them out on `tx_data` as 8N1 frames, LSB first. Bit timing comes from the shared `bclkx8` baud strobe: one bit lasts 8 `bclkx8` rising edges. Its serial output is the line consumed by the `receiver` block, and the two are paired for loopback.

## Interface
- `DATA_BITS`, default 8: payload bits per frame.
- `OVERSAMPLE`, default 8: `bclkx8` rising edges per bit period.

Ports:
- `sys_clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `bclkx8`  in  1: baud ×8 level signal from the baud generator. Only its rising edges, detected in the `sys_clk` domain, advance the block.
- `tx_load`  in  1: write strobe for the holding register (THR).
- `THR_in`  in  `DATA_BITS`: byte to transmit; sampled when `tx_load & tx_ready`.
- `tx_ready`  out  1: THR empty; a load is accepted this cycle.
- `tx_status`  out  1: frame in progress (any state other than IDLE).
- `tx_data`  out  1: serial line; idles high.

## Operation
- Tick detection:
  - `tick = bclkx8 & ~bclkx8_old`, where `bclkx8_old` is registered every cycle.
  - On reset, `bclkx8_old <= bclkx8`, so no spurious tick follows reset.
- Storage:
  - THR, with a full flag; `tx_ready = ~thr_full`, registered.
  - TSR, the shift register.
  - `count` (3 bits), the tick counter within a bit.
  - `bit_count` (4 bits).
- Load:
  - `tx_load` with `tx_ready = 1` captures `THR_in` and sets `thr_full`.
  - `tx_load` with `tx_ready = 0` is ignored silently; the data is dropped and no error is flagged.
- FSM states: IDLE, START, DATA, STOP. All transitions occur only on a tick.
- IDLE:
  - Drives `tx_data = 1`.
  - On a tick with `thr_full`: TSR ← THR, clear `thr_full`, reset `count` and `bit_count`, then → START.
- START:
  - Drives `tx_data = 0`.
  - When `count == OVERSAMPLE-1`: → DATA, `count` ← 0. Otherwise `count++`.
- DATA:
  - Drives `tx_data = TSR[0]`.
  - When `count == OVERSAMPLE-1`: shift TSR right, `bit_count++`, `count` ← 0.
  - After the shift for bit `DATA_BITS-1` (that is, `bit_count` reaching `DATA_BITS`): → STOP.
- STOP:
  - Drives `tx_data = 1`.
  - When `count == OVERSAMPLE-1`:
    - if `thr_full`: reload TSR from THR, clear `thr_full`, → START. This gives a back-to-back frame with no idle gap.
    - otherwise: → IDLE.
- `tx_data` is registered and updated in the same cycle as the state change.
- Arithmetic:
  - Counters wrap only through the explicit resets above. `count` never exceeds `OVERSAMPLE-1`.
  - Width rule: `$clog2(OVERSAMPLE)` bits for `count`, `$clog2(DATA_BITS+1)` bits for `bit_count`.

## Timing
- Values after reset: `tx_data = 1`, `tx_ready = 1`, `tx_status = 0`, state IDLE, THR and TSR = 0.
- Load to `tx_ready` low: 1 `sys_clk`.
- THR transfer to `tx_ready` high: 1 `sys_clk` after the transferring tick.
- Load to start-bit falling edge: the first tick detected after the cycle in which THR is written. Latency is 1 `sys_clk` up to one tick period plus 1.
- Frame length: (1 + `DATA_BITS` + 1) × `OVERSAMPLE` ticks, which is 80 ticks by default.
- Back-to-back frames:
  - Stop bit is exactly `OVERSAMPLE` ticks.
  - The next start bit begins on the following tick.
- Load and transfer can never coincide: a transfer needs `thr_full`, and a load needs `~thr_full`.
- `bclkx8` held static: no ticks, so the FSM freezes and outputs hold.
- `rst` mid-frame:
  - Next cycle: `tx_data = 1`, IDLE, `tx_ready = 1`.
  - THR and TSR contents are discarded.
  - `tx_load` asserted together with `rst` is ignored.

## Structure
- Shared package `uart_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`
  - `OVERSAMPLE_DEF = 8`
  - `DATA_BITS_DEF = 8`
- The `receiver` block imports the same package.
- One natural sub-module, `rise_detect` (`sys_clk`, `rst`, `sig_in`, `pulse_out`), with reset preload of the old value. It is reusable by `receiver`.

## Test plan
- **Reset:** `rst = 1` for 3 cycles, random `bclkx8` → `tx_data = 1`, `tx_ready = 1`, `tx_status = 0`, no ticks acted on.
- **Single byte 0xA5:** line is 0, then 1,0,1,0,0,1,0,1, then 1, each held 8 ticks. `tx_status` is high for exactly 80 ticks, then low.
- **Back-to-back 0x55 then 0x0F:** second byte loaded during the first frame's DATA → second start bit on the tick immediately after the first stop bit; 160 ticks total with no idle tick.
- **Overflow:** load 0x11 at IDLE, 0x22 after `tx_ready` rises, then 0x33 while `tx_ready = 0` → only 0x11 and 0x22 are transmitted, and `tx_ready` stays low until 0x22 transfers.
- **Loopback:** `tx_data` → `receiver.rx_data`, shared `bclkx8`, send 0x3C → `RHR == 8'h3C` after the stop bit.
- **Reset mid-DATA:** assert at bit 3 → `tx_data = 1` next cycle, `tx_ready = 1`. A subsequent load of 0x81 yields a clean, full 80-tick frame.
